dbg_guv_cmd_sched: RTL and testbench
====================================

// Module: dbg_guv_cmd_sched
// PURPOSE
//  Command sequencer for the debug governor datapath. Accepts 32-bit commands on the cmd_in AXI-Stream.
//  Drives per-channel drop/inject/pause/log enables for the governed channels (rdata,wdata,raddr,awaddr,resp).
//  Each command runs for a counted number of channel beats (or cycles for PAUSE), then reports done/err.
// PARAMETERS
//  NUM_CH          5    number of governed channels; channel index 0..NUM_CH-1
//  CNT_WIDTH       16   width of the command count field, cmd[CNT_WIDTH-1:0]; must be <=24
//  TIMEOUT_CYCLES  1024 beat-starvation limit (DBG_GUV_SCHED_TIMEOUT_EN only)
// PORTS
//  clk            in   1          clock
//  rst            in   1          asynchronous, active-low reset
//  cmd_in_TDATA   in   32         command word
//  cmd_in_TVALID  in   1          command valid
//  cmd_in_TREADY  out  1          command ready
//  ch_beat        in   NUM_CH     1-cycle pulse per completed TVALID&TREADY beat on each channel
//  abort          in   1          terminate active command
//  drop_en        out  NUM_CH     per-channel drop enable
//  inject_en      out  NUM_CH     per-channel inject enable
//  pause_en       out  NUM_CH     per-channel pause enable
//  log_en         out  NUM_CH     per-channel log enable
//  busy           out  1          high while state != IDLE
//  done           out  1          1-cycle pulse: command completed or aborted
//  err            out  1          1-cycle pulse: illegal command or timeout
// BEHAVIOUR
//  - Command format:
//    - [31:28] op: 0=NOP, 1=DROP, 2=INJECT, 3=PAUSE, 4=LOG, 5..15 illegal.
//    - [27:24] channel; a channel >=NUM_CH is illegal.
//    - [23:CNT_WIDTH] ignored; [CNT_WIDTH-1:0] count.
//  - Reset (rst low, async): state=IDLE; all enables=0; busy=done=err=0; cmd_in_TREADY=0 while rst low.
//  - States: IDLE, ACTIVE, DONE, ERR. All outputs except cmd_in_TREADY are registered.
//  - IDLE: cmd_in_TREADY=1. Accept on TVALID&TREADY at edge E0; latch op/ch/count into a remaining counter.
//    - illegal op or channel -> ERR.
//    - NOP or count==0 -> DONE; no enable is asserted.
//    - else -> ACTIVE; the single enable bit [ch] of the op's vector is set after E0.
//  - ACTIVE: cmd_in_TREADY=0; exactly one enable bit is high.
//    - Decrement event: DROP/INJECT/LOG on ch_beat[ch]; PAUSE on every cycle.
//    - ch_beat on other channels is ignored.
//    - When the decrement event occurs with remaining==1 -> DONE; the enable clears at that same edge.
//    - Result: the enable covers exactly count beats; for PAUSE it is high exactly count cycles.
//    - abort=1 -> DONE; the enable clears. Abort together with the final beat gives the same result (single done).
//  - DONE: done=1 for one cycle -> IDLE. ERR: err=1 for one cycle, no enables -> IDLE.
//  - Minimum command-to-command spacing is 3 cycles (accept, DONE, IDLE).
//  - Counter never wraps: it decrements only while ACTIVE and remaining>=1.
//  - abort in IDLE, DONE or ERR is ignored.
//  - rst asserted mid-ACTIVE clears all state immediately; no done pulse.
// CONFIGURATION
//  - DBG_GUV_SCHED_TIMEOUT_EN defined:
//    - A starvation counter resets on entry to ACTIVE and on each ch_beat[ch].
//    - For non-PAUSE ops it increments every ACTIVE cycle.
//    - On reaching TIMEOUT_CYCLES -> ERR: enables clear, err pulses, no done.
//    - abort has priority over timeout in the same cycle.
//  - Not defined: no counter is built; ACTIVE waits indefinitely for beats; TIMEOUT_CYCLES is unused.
// TESTING
//  1. Reset: hold rst low 5 cycles -> all outputs 0, cmd_in_TREADY=0; release -> cmd_in_TREADY=1 the next cycle.
//  2. DROP: cmd 0x1100_0003; ch_beat[0] pulses interleaved with 3 ch_beat[1] pulses
//     -> drop_en=5'b00010 until the 3rd ch_beat[1], then done for 1 cycle, then IDLE.
//  3. PAUSE: cmd 0x3400_0004 -> pause_en=5'b10000 for exactly 4 cycles, then done; TREADY=0 throughout.
//  4. Illegal: cmds 0x7000_0001 and 0x1900_0001 -> err pulse each; all enables stay 0; no done.
//  5. Zero count: cmd 0x2200_0000 -> done the cycle after acceptance; inject_en never set.
//     Abort: cmd 0x1000_0005 with abort after 1 beat -> drop_en clears and done pulses.
//  6. Timeout (DBG_GUV_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16): cmd 0x2000_0002 with no beats
//     -> inject_en[0] high 16 cycles, then err pulse and no done.
//     Without the macro: still busy after 1000 cycles.

Source files
------------

// File: rtl/dbg_guv_cmd_sched.sv
// dbg_guv_cmd_sched: command sequencer for the debug governor datapath.
// Accepts 32-bit commands (op/channel/count) and drives one per-channel
// drop/inject/pause/log enable for a counted number of beats (cycles for PAUSE).
// Optional feature macro: DBG_GUV_SCHED_TIMEOUT_EN adds a beat-starvation
// timeout that ends a stalled command with an err pulse.
module dbg_guv_cmd_sched #(
   parameter int NUM_CH         = 5,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       cmd_in_TDATA,
   input  logic              cmd_in_TVALID,
   output logic              cmd_in_TREADY,
   input  logic [NUM_CH-1:0] ch_beat,
   input  logic              abort,
   output logic [NUM_CH-1:0] drop_en,
   output logic [NUM_CH-1:0] inject_en,
   output logic [NUM_CH-1:0] pause_en,
   output logic [NUM_CH-1:0] log_en,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2,
      ST_ERR    = 2'd3
   } state_t;

   localparam logic [3:0] OP_NOP    = 4'd0;
   localparam logic [3:0] OP_DROP   = 4'd1;
   localparam logic [3:0] OP_INJECT = 4'd2;
   localparam logic [3:0] OP_PAUSE  = 4'd3;
   localparam logic [3:0] OP_LOG    = 4'd4;
   localparam logic [4:0] NUM_CH_W  = 5'(NUM_CH);

   state_t                state_q, state_d;
   logic [3:0]            op_q, op_d;
   logic [3:0]            ch_q, ch_d;
   logic [CNT_WIDTH-1:0]  rem_q, rem_d;
   logic                  rdy_q, rdy_d;
   logic [NUM_CH-1:0]     drop_en_q, drop_en_d;
   logic [NUM_CH-1:0]     inject_en_q, inject_en_d;
   logic [NUM_CH-1:0]     pause_en_q, pause_en_d;
   logic [NUM_CH-1:0]     log_en_q, log_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [3:0]            cmd_op;
   logic [3:0]            cmd_ch;
   logic                  cmd_illegal;
   logic                  accept;
   logic                  beat_sel;
   logic                  dec_evt;
   logic                  timeout_hit;
   logic [NUM_CH-1:0]     ch_onehot;

   assign cmd_op        = cmd_in_TDATA[31:28];
   assign cmd_ch        = cmd_in_TDATA[27:24];
   assign cmd_illegal   = (cmd_op > OP_LOG) || ({1'b0, cmd_ch} >= NUM_CH_W);
   // rdy_q keeps TREADY low while reset is held and for the release cycle
   assign cmd_in_TREADY = rdy_q && (state_q == ST_IDLE);
   assign accept        = cmd_in_TREADY && cmd_in_TVALID;
   assign dec_evt       = (op_q == OP_PAUSE) || beat_sel;
   assign rdy_d         = 1'b1;

   // Bits between the count field and the channel field carry no meaning
   generate
      if (CNT_WIDTH < 24) begin : g_unused_bits
         logic unused_cmd_bits;
         assign unused_cmd_bits = ^cmd_in_TDATA[23:CNT_WIDTH];
      end
   endgenerate

   // Select the beat strobe of the channel owned by the active command
   always_comb begin : beat_select
      beat_sel = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_q == 4'(i)) beat_sel = ch_beat[i];
      end
   end

`ifdef DBG_GUV_SCHED_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
   logic [SW-1:0] starve_q, starve_d;

   // Starvation counter: cleared on entry and on each owned beat; PAUSE never starves
   always_comb begin : starve_comb
      starve_d = starve_q;
      if (state_q != ST_ACTIVE) starve_d = '0;
      else if (beat_sel) starve_d = '0;
      else if (op_q != OP_PAUSE) starve_d = starve_q + SW'(1);
   end

   assign timeout_hit = (op_q != OP_PAUSE) && !beat_sel &&
                        (starve_q == SW'(TIMEOUT_CYCLES - 1));

   // Starvation counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) starve_q <= '0;
      else      starve_q <= starve_d;
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout_hit = 1'b0;
`endif

   // Next-state logic and command/remaining-count capture
   always_comb begin : next_state_comb
      state_d = state_q;
      op_d    = op_q;
      ch_d    = ch_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d  = cmd_op;
               ch_d  = cmd_ch;
               rem_d = cmd_in_TDATA[CNT_WIDTH-1:0];
               if (cmd_illegal) state_d = ST_ERR;
               else if (cmd_op == OP_NOP || cmd_in_TDATA[CNT_WIDTH-1:0] == '0)
                  state_d = ST_DONE;
               else state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            // Counter only moves while something is left, so it cannot wrap
            if (dec_evt && rem_q != '0) rem_d = rem_q - CNT_WIDTH'(1);
            if (abort) state_d = ST_DONE;
            else if (dec_evt && rem_q == CNT_WIDTH'(1)) state_d = ST_DONE;
            else if (timeout_hit) state_d = ST_ERR;
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // One-hot decode of the channel the next state will govern
   always_comb begin : ch_decode
      ch_onehot = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_onehot[i] = (ch_d == 4'(i));
      end
   end

   // Registered outputs are derived from the next state so they align with it
   always_comb begin : output_comb
      drop_en_d   = '0;
      inject_en_d = '0;
      pause_en_d  = '0;
      log_en_d    = '0;
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      err_d       = (state_d == ST_ERR);
      if (state_d == ST_ACTIVE) begin
         case (op_d)
            OP_DROP:   drop_en_d   = ch_onehot;
            OP_INJECT: inject_en_d = ch_onehot;
            OP_PAUSE:  pause_en_d  = ch_onehot;
            OP_LOG:    log_en_d    = ch_onehot;
            default:   ;
         endcase
      end
   end

   // State register and captured command fields
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         ch_q    <= '0;
         rem_q   <= '0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         ch_q    <= ch_d;
         rem_q   <= rem_d;
         rdy_q   <= rdy_d;
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_en_q   <= '0;
         inject_en_q <= '0;
         pause_en_q  <= '0;
         log_en_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         drop_en_q   <= drop_en_d;
         inject_en_q <= inject_en_d;
         pause_en_q  <= pause_en_d;
         log_en_q    <= log_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign drop_en   = drop_en_q;
   assign inject_en = inject_en_q;
   assign pause_en  = pause_en_q;
   assign log_en    = log_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_dbg_guv_cmd_sched.sv
// Testbench for dbg_guv_cmd_sched: directed scenarios plus randomized commands
// checked cycle by cycle against a transaction-level reference model.
module tb_dbg_guv_cmd_sched;
   localparam int NUM_CH = 5;
   localparam int TO     = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [31:0]       tdata = '0;
   logic              tvalid = 1'b0;
   logic              tready;
   logic [NUM_CH-1:0] ch_beat = '0;
   logic              abort = 1'b0;
   logic [NUM_CH-1:0] drop_en, inject_en, pause_en, log_en;
   logic              busy, done, err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dbg_guv_cmd_sched #(
      .NUM_CH(NUM_CH), .CNT_WIDTH(16), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_in_TDATA(tdata), .cmd_in_TVALID(tvalid), .cmd_in_TREADY(tready),
      .ch_beat(ch_beat), .abort(abort),
      .drop_en(drop_en), .inject_en(inject_en), .pause_en(pause_en), .log_en(log_en),
      .busy(busy), .done(done), .err(err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag,
                             input logic [NUM_CH-1:0] e_drop, input logic [NUM_CH-1:0] e_inj,
                             input logic [NUM_CH-1:0] e_pause, input logic [NUM_CH-1:0] e_log,
                             input logic e_busy, input logic e_done, input logic e_err,
                             input logic e_rdy);
      check({tag, ".drop_en"},   32'(drop_en),   32'(e_drop));
      check({tag, ".inject_en"}, 32'(inject_en), 32'(e_inj));
      check({tag, ".pause_en"},  32'(pause_en),  32'(e_pause));
      check({tag, ".log_en"},    32'(log_en),    32'(e_log));
      check({tag, ".busy"},      32'(busy),      32'(e_busy));
      check({tag, ".done"},      32'(done),      32'(e_done));
      check({tag, ".err"},       32'(err),       32'(e_err));
      check({tag, ".tready"},    32'(tready),    32'(e_rdy));
   endtask

   // Issue one command and follow it to completion. Model: a legal non-empty
   // command owns one enable bit until `count` owned beats (cycles for PAUSE)
   // have been seen or abort arrives; with the timeout feature, TO consecutive
   // beat-less cycles of a non-PAUSE command end it with err.
   task automatic run_cmd(input logic [31:0] cmd, input int beat_pct, input int abort_after);
      logic [3:0]        op, ch;
      int                cnt, left, idle, n;
      bit                legal, hit, ab, fin_done, fin_err;
      logic [NUM_CH-1:0] vec, beats, ed, ei, ep, el;
      op    = cmd[31:28];
      ch    = cmd[27:24];
      cnt   = int'(cmd[15:0]);
      legal = (op <= 4'd4) && (int'(ch) < NUM_CH);
      n = 0;
      while (tready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_cmd", 32'(tready), 32'd1);
      tdata  = cmd;
      tvalid = 1'b1;
      @(negedge clk);
      tvalid = 1'b0;
      tdata  = $urandom();
      if (!legal) begin
         check_outs("illegal", '0, '0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
      end else if (op == 4'd0 || cnt == 0) begin
         check_outs("empty", '0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      end else begin
         vec = '0;
         vec[ch] = 1'b1;
         ed = (op == 4'd1) ? vec : '0;
         ei = (op == 4'd2) ? vec : '0;
         ep = (op == 4'd3) ? vec : '0;
         el = (op == 4'd4) ? vec : '0;
         left = cnt; idle = 0; n = 0; fin_done = 0; fin_err = 0;
         while (!fin_done && !fin_err) begin
            check_outs("active", ed, ei, ep, el, 1'b1, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < NUM_CH; i++) beats[i] = ($urandom_range(99) < beat_pct);
            ab      = (n == abort_after);
            ch_beat = beats;
            abort   = ab;
            @(negedge clk);
            ch_beat = '0;
            abort   = 1'b0;
            n++;
            hit = (op == 4'd3) || beats[ch];
            if (ab) fin_done = 1;
            else if (hit && left == 1) fin_done = 1;
            else begin
               if (hit) left--;
`ifdef DBG_GUV_SCHED_TIMEOUT_EN
               if (op != 4'd3) begin
                  if (beats[ch]) idle = 0;
                  else idle++;
                  if (idle == TO) fin_err = 1;
               end
`endif
            end
            if (!fin_done && !fin_err && n > 1200) begin
               tests++;
               fails++;
               $error("FAIL cycle_bound: command 0x%0h still active after %0d cycles, required completion", cmd, n);
               return;
            end
         end
         if (fin_done) check_outs("finish_done", '0, '0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
         else          check_outs("finish_timeout", '0, '0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      @(negedge clk);
      check_outs("back_to_idle", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      $display("[TB] cmd 0x%08h done (tests=%0d failed=%0d)", cmd, tests, fails);
   endtask

   initial begin
      logic [31:0] rc;
      int          pct, abt;
      #1 rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check_outs("reset", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      rst = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 32'(tready), 32'd1);
      check("busy_after_reset", 32'(busy), 32'd0);

      // abort and beats while idle are ignored
      abort = 1'b1; ch_beat = '1;
      @(negedge clk);
      abort = 1'b0; ch_beat = '0;
      check_outs("idle_abort", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

      run_cmd(32'h1100_0003, 50, -1);   // DROP ch1, interleaved beats
      run_cmd(32'h3400_0004, 0, -1);    // PAUSE ch4, 4 cycles
      run_cmd(32'h7000_0001, 50, -1);   // illegal op
      run_cmd(32'h1900_0001, 50, -1);   // illegal channel
      run_cmd(32'h2200_0000, 50, -1);   // zero count
      run_cmd(32'h0300_0007, 50, -1);   // NOP
      run_cmd(32'h1000_0005, 100, 1);   // abort after one beat
      run_cmd(32'h4300_0001, 100, 0);   // abort together with final beat
      run_cmd(32'h32AB_0002, 0, -1);    // ignored middle bits
      run_cmd(32'h3000_0001, 0, -1);    // PAUSE count 1
      run_cmd(32'h2000_0002, 0, 1000);  // starvation: timeout or still busy until abort

      for (int k = 0; k < 60; k++) begin
         rc = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 5)), 8'($urandom()),
               16'($urandom_range(0, 6))};
         pct = int'($urandom_range(30, 90));
         abt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
         run_cmd(rc, pct, abt);
      end

      // reset in the middle of an active command clears everything at once
      @(negedge clk);
      check("ready_mid_rst", 32'(tready), 32'd1);
      tdata = 32'h4200_0009; tvalid = 1'b1;
      @(negedge clk);
      tvalid = 1'b0;
      @(negedge clk);
      check("mid_log_en", 32'(log_en), 32'h4);
      #2 rst = 1'b0;
      #1 check_outs("async_reset", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check_outs("held_reset", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check_outs("after_mid_reset", '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
